// File: rtl/data_bus_router.sv
// MMIO router: decodes arbitrated data-path requests to CLINT/PLIC/UART and runs the slave req/ack handshake.
// Optional slave-ack timeout enabled by defining DBR_TIMEOUT_EN.
module data_bus_router #(
`ifdef DBR_TIMEOUT_EN
    parameter int unsigned TO_CYC  = 255,
`endif
    parameter logic [31:0] S0_BASE = 32'h0200_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h0C00_0000,
    parameter logic [31:0] S1_MASK = 32'hFC00_0000,
    parameter logic [31:0] S2_BASE = 32'h1000_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_F000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] data_paddr,
    input  logic        data_le,
    input  logic        data_we,
    input  logic [31:0] data_wdata,
    output logic [3:0]  data_busy,
    output logic [31:0] data_rdata,
    output logic [2:0]  s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [2:0]  s_ack,
    input  logic [31:0] s_rdata0,
    input  logic [31:0] s_rdata1,
    input  logic [31:0] s_rdata2,
    output logic        err_sticky
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      busy_q, busy_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2:0]      s_req_q, s_req_d;
    logic            s_we_q, s_we_d;
    logic [DW-1:0]   s_addr_q, s_addr_d;
    logic [DW-1:0]   s_wdata_q, s_wdata_d;
    logic            err_q, err_d;

`ifdef DBR_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic            hit0, hit1, hit2;
    logic            ack_hit;
    logic [DW-1:0]   sel_rdata;

    assign hit0 = (data_paddr & S0_MASK) == S0_BASE;
    assign hit1 = (data_paddr & S1_MASK) == S1_BASE;
    assign hit2 = (data_paddr & S2_MASK) == S2_BASE;

    // Only the ack of the slave we are talking to counts
    assign ack_hit   = |(s_ack & busy_q[2:0]);
    assign sel_rdata = ({DW{busy_q[0]}} & s_rdata0)
                     | ({DW{busy_q[1]}} & s_rdata1)
                     | ({DW{busy_q[2]}} & s_rdata2);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        rdata_d   = rdata_q;
        s_req_d   = 3'b000;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        err_d     = err_q;
`ifdef DBR_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_le || data_we) begin
                    // A simultaneous le/we is serviced as a write but flagged
                    s_we_d    = data_we;
                    s_wdata_d = data_wdata;
                    if (data_le && data_we) err_d = 1'b1;
                    state_d   = REQ;
                    if (hit0) begin
                        busy_d   = 4'b0001;
                        s_req_d  = 3'b001;
                        s_addr_d = data_paddr - S0_BASE;
                    end else if (hit1) begin
                        busy_d   = 4'b0010;
                        s_req_d  = 3'b010;
                        s_addr_d = data_paddr - S1_BASE;
                    end else if (hit2) begin
                        busy_d   = 4'b0100;
                        s_req_d  = 3'b100;
                        s_addr_d = data_paddr - S2_BASE;
                    end else begin
                        busy_d   = 4'b1000;
                        s_addr_d = data_paddr;
                        rdata_d  = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            REQ: begin
                state_d = WAIT;
`ifdef DBR_TIMEOUT_EN
                cnt_d   = '0;
`endif
                if (ack_hit) begin
                    rdata_d = s_we_q ? '0 : sel_rdata;
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (ack_hit) begin
                    rdata_d = s_we_q ? '0 : sel_rdata;
                    state_d = DONE;
                end
`ifdef DBR_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TO_CYC)) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                busy_d  = 4'b0000;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            busy_q    <= '0;
            rdata_q   <= '0;
            s_req_q   <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            err_q     <= 1'b0;
`ifdef DBR_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            err_q     <= err_d;
`ifdef DBR_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign data_busy  = busy_q;
    assign data_rdata = rdata_q;
    assign s_req      = s_req_q;
    assign s_we       = s_we_q;
    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_data_bus_router.sv
// Directed bench for data_bus_router; define DBR_TIMEOUT_EN to also exercise the ack timeout (TO_CYC=8).
module tb_data_bus_router;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] data_paddr;
    logic        data_le;
    logic        data_we;
    logic [31:0] data_wdata;
    logic [3:0]  data_busy;
    logic [31:0] data_rdata;
    logic [2:0]  s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_ack;
    logic [31:0] s_rdata0, s_rdata1, s_rdata2;
    logic        err_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    data_bus_router #(
`ifdef DBR_TIMEOUT_EN
        .TO_CYC(8)
`endif
    ) dut (
        .CLK(CLK), .RST(RST),
        .data_paddr(data_paddr), .data_le(data_le), .data_we(data_we), .data_wdata(data_wdata),
        .data_busy(data_busy), .data_rdata(data_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata0(s_rdata0), .s_rdata1(s_rdata1), .s_rdata2(s_rdata2),
        .err_sticky(err_sticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one access and play the slave: ack 'dly' cycles after s_req is seen, optional stray ack from another slave.
    task automatic run_access(input logic [31:0] addr, input logic rd, input logic wr, input logic [31:0] wd,
                              input int slave, input int dly, input logic [31:0] rdat, input int stray,
                              output int span, output logic [3:0] busy_v, output logic [2:0] req_v,
                              output logic [31:0] addr_v, output logic we_v, output logic [31:0] wd_v);
        int cyc;
        int t_req;
        int busy_len;
        @(negedge CLK);
        data_paddr = addr; data_le = rd; data_we = wr; data_wdata = wd;
        @(posedge CLK); #1;
        data_le = 1'b0; data_we = 1'b0;
        busy_v = data_busy; req_v = 3'b000; addr_v = s_addr; we_v = s_we; wd_v = s_wdata;
        cyc = 0; t_req = -1; busy_len = 0;
        while (data_busy != 4'b0000 && cyc < 400) begin
            busy_len++;
            if (s_req != 3'b000) begin
                t_req = cyc; req_v = s_req; addr_v = s_addr; we_v = s_we; wd_v = s_wdata;
            end
            s_ack = 3'b000;
            if (slave >= 0 && t_req >= 0 && cyc == t_req + dly) begin
                s_ack[slave] = 1'b1;
                s_rdata0 = rdat; s_rdata1 = rdat; s_rdata2 = rdat;
            end
            if (stray >= 0 && t_req >= 0 && cyc == t_req + 1) begin
                s_ack[stray] = 1'b1;
                if (stray == 0) s_rdata0 = 32'hDEAD_BEEF;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        s_ack = 3'b000;
        check("access_terminates", 32'(cyc < 400), 32'd1);
        span = busy_len + 1;
    endtask

    task automatic do_reset();
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK); RST = 1'b0;
    endtask

    int          span;
    logic [3:0]  busy_v;
    logic [2:0]  req_v;
    logic [31:0] addr_v;
    logic        we_v;
    logic [31:0] wd_v;

    initial begin
        RST = 1'b1; data_paddr = '0; data_le = 1'b0; data_we = 1'b0; data_wdata = '0;
        s_ack = '0; s_rdata0 = '0; s_rdata1 = '0; s_rdata2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", 32'(data_busy), 32'h0);
        check("rst_rdata", data_rdata, 32'h0);
        check("rst_s_req", 32'(s_req), 32'h0);
        check("rst_s_we", 32'(s_we), 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_s_wdata", s_wdata, 32'h0);
        check("rst_err", 32'(err_sticky), 32'h0);
        @(negedge CLK); RST = 1'b0;

        // CLINT read, 1-cycle ack
        run_access(32'h0200_BFF8, 1'b1, 1'b0, 32'h0, 0, 1, 32'h1234_5678, -1,
                   span, busy_v, req_v, addr_v, we_v, wd_v);
        check("rd_s0_busy", 32'(busy_v), 32'h1);
        check("rd_s0_req", 32'(req_v), 32'h1);
        check("rd_s0_addr", addr_v, 32'h0000_BFF8);
        check("rd_s0_we", 32'(we_v), 32'h0);
        check("rd_s0_span", 32'(span), 32'd4);
        check("rd_s0_rdata", data_rdata, 32'h1234_5678);
        check("rd_s0_err", 32'(err_sticky), 32'h0);
        repeat (3) @(posedge CLK);
        #1 check("rdata_hold_idle", data_rdata, 32'h1234_5678);

        // PLIC read acked in the REQ cycle
        run_access(32'h0C00_0010, 1'b1, 1'b0, 32'h0, 1, 0, 32'hCAFE_0001, -1,
                   span, busy_v, req_v, addr_v, we_v, wd_v);
        check("rd_s1_req", 32'(req_v), 32'h2);
        check("rd_s1_addr", addr_v, 32'h0000_0010);
        check("rd_s1_span", 32'(span), 32'd3);
        check("rd_s1_rdata", data_rdata, 32'hCAFE_0001);

        // Reset in WAIT of a CLINT read, then a stale ack
        @(negedge CLK);
        data_paddr = 32'h0200_0004; data_le = 1'b1;
        @(posedge CLK); #1;
        data_le = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_busy", 32'(data_busy), 32'h0);
        check("mid_rst_s_req", 32'(s_req), 32'h0);
        RST = 1'b0; s_ack = 3'b001; s_rdata0 = 32'hBAD0_BAD0;
        @(posedge CLK); #1;
        s_ack = 3'b000;
        @(posedge CLK); #1;
        check("stale_ack_busy", 32'(data_busy), 32'h0);
        check("stale_ack_rdata", data_rdata, 32'h0);

        // UART write, ack after 3 cycles, stray CLINT ack ignored
        run_access(32'h1000_0000, 1'b0, 1'b1, 32'h41, 2, 3, 32'h5555_5555, 0,
                   span, busy_v, req_v, addr_v, we_v, wd_v);
        check("wr_s2_busy", 32'(busy_v), 32'h4);
        check("wr_s2_req", 32'(req_v), 32'h4);
        check("wr_s2_we", 32'(we_v), 32'h1);
        check("wr_s2_wdata", wd_v, 32'h41);
        check("wr_s2_addr", addr_v, 32'h0);
        check("wr_s2_span", 32'(span), 32'd6);
        check("wr_s2_rdata", data_rdata, 32'h0);
        check("wr_s2_err", 32'(err_sticky), 32'h0);

        // Unmapped read after a nonzero read
        run_access(32'h0C00_0020, 1'b1, 1'b0, 32'h0, 1, 1, 32'h0BAD_F00D, -1,
                   span, busy_v, req_v, addr_v, we_v, wd_v);
        check("rd_s1b_rdata", data_rdata, 32'h0BAD_F00D);
        run_access(32'h8000_0000, 1'b1, 1'b0, 32'h0, -1, 0, 32'h0, -1,
                   span, busy_v, req_v, addr_v, we_v, wd_v);
        check("unmap_busy", 32'(busy_v), 32'h8);
        check("unmap_req", 32'(req_v), 32'h0);
        check("unmap_span", 32'(span), 32'd2);
        check("unmap_rdata", data_rdata, 32'h0);
        check("unmap_err", 32'(err_sticky), 32'h1);

        // le & we collision to PLIC
        do_reset();
        #1 check("err_cleared", 32'(err_sticky), 32'h0);
        run_access(32'h0C00_0004, 1'b1, 1'b1, 32'h77, 1, 1, 32'h1111_2222, -1,
                   span, busy_v, req_v, addr_v, we_v, wd_v);
        check("coll_req", 32'(req_v), 32'h2);
        check("coll_we", 32'(we_v), 32'h1);
        check("coll_addr", addr_v, 32'h4);
        check("coll_rdata", data_rdata, 32'h0);
        check("coll_err", 32'(err_sticky), 32'h1);

`ifdef DBR_TIMEOUT_EN
        // PLIC never acks: timeout after TO_CYC=8 wait cycles
        do_reset();
        run_access(32'h0C00_0000, 1'b1, 1'b0, 32'h0, -1, 0, 32'h0, -1,
                   span, busy_v, req_v, addr_v, we_v, wd_v);
        check("to_span", 32'(span), 32'd12);
        check("to_rdata", data_rdata, 32'hFFFF_FFFF);
        check("to_err", 32'(err_sticky), 32'h1);
        @(negedge CLK); s_ack = 3'b010; s_rdata1 = 32'h0000_0055;
        @(posedge CLK); #1; s_ack = 3'b000;
        @(posedge CLK); #1;
        check("to_late_busy", 32'(data_busy), 32'h0);
        check("to_late_rdata", data_rdata, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
